// File: rtl/uart_rx_sampler.sv
// UART receive engine: 16x oversampling deframer with a valid/read handshake
// and parity, framing and overflow status towards the FIFO/APB side.
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       read_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       PAR_ODD   = 1'(PARITY_ODD);
    localparam logic [7:0] DATA_MASK = (DATA_BITS == 7) ? 8'h7F : 8'hFF;

    state_e     state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;

    logic       rx_meta_q, rx_s_q;
    logic [7:0] shift_q;
    logic       par_tmp_q;
    logic       stop_bit_q;
    logic       done_q;

    logic [7:0] rx_data_q;
    logic       rx_valid_q, parity_err_q, framing_err_q, overflow_q;

    logic       mid_bit;
    logic       sample_data, sample_par, sample_stop, begin_data;

    assign mid_bit = baud_clock && (tick_q == 4'd15);

    // FSM state register; everything in the FSM moves only on baud ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of its neighbours.
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a target unassigned (no latch).
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        if (baud_clock) begin
            unique case (state_q)
                IDLE: begin
                    tick_d = 4'd0;
                    if (!rx_s_q) state_d = START;
                end
                START: begin
                    if (tick_q == 4'd7) begin
                        tick_d  = 4'd0;
                        bit_d   = 3'd0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == LAST_BIT) begin
                            bit_d   = 3'd0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) state_d = STOP;
                end
                STOP: begin
                    // Back to IDLE on the sample tick so a back-to-back start is caught.
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sample_data = mid_bit && (state_q == DATA);
        sample_par  = mid_bit && (state_q == PARITY);
        sample_stop = mid_bit && (state_q == STOP);
        begin_data  = baud_clock && (state_q == START) && (tick_q == 4'd7) && !rx_s_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchroniser resets to the idle line level to avoid a phantom start.
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            shift_q       <= 8'h00;
            par_tmp_q     <= 1'b0;
            stop_bit_q    <= 1'b1;
            done_q        <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            done_q    <= sample_stop;

            if (begin_data)  par_tmp_q <= 1'b0;
            if (sample_data) shift_q[bit_q] <= rx_s_q;
            if (sample_par)  par_tmp_q <= rx_s_q ^ (^shift_q) ^ PAR_ODD;
            if (sample_stop) stop_bit_q <= rx_s_q;

            // A read in the completion cycle frees the slot for the new word.
            if (done_q) begin
                if (!rx_valid_q || read_rx) begin
                    rx_data_q     <= shift_q & DATA_MASK;
                    parity_err_q  <= par_tmp_q;
                    framing_err_q <= ~stop_bit_q;
                    rx_valid_q    <= 1'b1;
                    overflow_q    <= overflow_q & ~read_rx;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (read_rx && rx_valid_q) begin
                rx_valid_q <= 1'b0;
                overflow_q <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: 8N1, 8E1 and 7N1 instances share clk,
// reset and a baud strobe every 4 clks; each has its own rx line and read pulse.
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_clock = 1'b0;
    logic [1:0] baud_div = 2'd0;

    logic       rx_m = 1'b1, rd_m = 1'b0;
    logic       rx_p = 1'b1, rd_p = 1'b0;
    logic       rx_7 = 1'b1, rd_7 = 1'b0;

    logic [7:0] data_m, data_p, data_7;
    logic       valid_m, perr_m, ferr_m, ovf_m;
    logic       valid_p, perr_p, ferr_p, ovf_p;
    logic       valid_7, perr_7, ferr_7, ovf_7;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_sampler #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx_m), .read_rx(rd_m),
        .rx_data(data_m), .rx_valid(valid_m), .parity_err(perr_m),
        .framing_err(ferr_m), .overflow(ovf_m));

    uart_rx_sampler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
        .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx_p), .read_rx(rd_p),
        .rx_data(data_p), .rx_valid(valid_p), .parity_err(perr_p),
        .framing_err(ferr_p), .overflow(ovf_p));

    uart_rx_sampler #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_7 (
        .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx_7), .read_rx(rd_7),
        .rx_data(data_7), .rx_valid(valid_7), .parity_err(perr_7),
        .framing_err(ferr_7), .overflow(ovf_7));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        baud_div   = baud_div + 2'd1;
        baud_clock = (baud_div == 2'd3);
    end

    task automatic drive_rx(input int sel, input logic v);
        case (sel)
            0:       rx_m = v;
            1:       rx_p = v;
            default: rx_7 = v;
        endcase
    endtask

    task automatic pulse_read(input int sel);
        @(negedge clk);
        case (sel)
            0:       rd_m = 1'b1;
            1:       rd_p = 1'b1;
            default: rd_7 = 1'b1;
        endcase
        @(negedge clk);
        rd_m = 1'b0;
        rd_p = 1'b0;
        rd_7 = 1'b0;
    endtask

    // Start edge is aligned just after a tick, so the stop sample lands 36 clks
    // into the stop bit and the completion edge follows one clk later.
    task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                              input bit has_par, input logic par_bit,
                              input logic stop_bit, input bit rd_at_done);
        @(posedge clk iff baud_clock);
        @(negedge clk);
        drive_rx(sel, 1'b0);
        repeat (64) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            drive_rx(sel, data[i]);
            repeat (64) @(negedge clk);
        end
        if (has_par) begin
            drive_rx(sel, par_bit);
            repeat (64) @(negedge clk);
        end
        drive_rx(sel, stop_bit);
        for (int c = 0; c < 64; c++) begin
            if (rd_at_done) rd_m = (c == 36);
            @(negedge clk);
        end
        rd_m = 1'b0;
        drive_rx(sel, 1'b1);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (data_m !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_m); end
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_m); end
        n_checks++; if (perr_m !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr_m); end
        n_checks++; if (ferr_m !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr_m); end
        n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_m); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic_frame;
        send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_m !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", data_m); end
        n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", valid_m); end
        n_checks++; if (perr_m !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", perr_m); end
        n_checks++; if (ferr_m !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", ferr_m); end
        pulse_read(0);
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL basic_read_valid: got %b want 0", valid_m); end
        pulse_read(0);
        n_checks++; if (valid_m !== 1'b0 || ovf_m !== 1'b0) begin n_fail++; $display("FAIL idle_read: got valid %b ovf %b want 0 0", valid_m, ovf_m); end
    endtask

    task automatic test_parity;
        send_frame(1, 8'h03, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (data_p !== 8'h03) begin n_fail++; $display("FAIL par_bad_data: got %h want 03", data_p); end
        n_checks++; if (perr_p !== 1'b1) begin n_fail++; $display("FAIL par_bad_perr: got %b want 1", perr_p); end
        n_checks++; if (valid_p !== 1'b1) begin n_fail++; $display("FAIL par_bad_valid: got %b want 1", valid_p); end
        pulse_read(1);
        send_frame(1, 8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_p !== 8'h03) begin n_fail++; $display("FAIL par_ok_data: got %h want 03", data_p); end
        n_checks++; if (perr_p !== 1'b0) begin n_fail++; $display("FAIL par_ok_perr: got %b want 0", perr_p); end
        n_checks++; if (ferr_p !== 1'b0) begin n_fail++; $display("FAIL par_ok_ferr: got %b want 0", ferr_p); end
        pulse_read(1);
    endtask

    task automatic test_framing;
        send_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (data_m !== 8'h5A) begin n_fail++; $display("FAIL frame_data: got %h want 5a", data_m); end
        n_checks++; if (ferr_m !== 1'b1) begin n_fail++; $display("FAIL frame_ferr: got %b want 1", ferr_m); end
        n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL frame_valid: got %b want 1", valid_m); end
        // Let the short re-frame started by the low tail of the stop bit die out.
        repeat (128) @(negedge clk);
        pulse_read(0);
        n_checks++; if (ferr_m !== 1'b1 || valid_m !== 1'b0) begin n_fail++; $display("FAIL frame_hold: got ferr %b valid %b want 1 0", ferr_m, valid_m); end
    endtask

    task automatic test_false_start;
        @(posedge clk iff baud_clock);
        @(negedge clk);
        rx_m = 1'b0;
        repeat (20) @(negedge clk);
        rx_m = 1'b1;
        repeat (80) @(negedge clk);
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL false_start_valid: got %b want 0", valid_m); end
        send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_m !== 8'h3C) begin n_fail++; $display("FAIL after_false_data: got %h want 3c", data_m); end
        n_checks++; if (ferr_m !== 1'b0 || valid_m !== 1'b1) begin n_fail++; $display("FAIL after_false_flags: got ferr %b valid %b want 0 1", ferr_m, valid_m); end
        pulse_read(0);
    endtask

    task automatic test_back_to_back;
        send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_m !== 8'h11) begin n_fail++; $display("FAIL ovf_data: got %h want 11", data_m); end
        n_checks++; if (ovf_m !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_m); end
        n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", valid_m); end
        pulse_read(0);
        n_checks++; if (valid_m !== 1'b0 || ovf_m !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got valid %b ovf %b want 0 0", valid_m, ovf_m); end
        send_frame(0, 8'h44, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_m !== 8'h44) begin n_fail++; $display("FAIL pre_collide_data: got %h want 44", data_m); end
        send_frame(0, 8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (data_m !== 8'h33) begin n_fail++; $display("FAIL collide_data: got %h want 33", data_m); end
        n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL collide_ovf: got %b want 0", ovf_m); end
        n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL collide_valid: got %b want 1", valid_m); end
    endtask

    task automatic test_reset_mid_frame;
        @(posedge clk iff baud_clock);
        @(negedge clk);
        rx_m = 1'b0;
        repeat (64) @(negedge clk);
        rx_m = 1'b1;
        repeat (150) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (data_m !== 8'h00 || valid_m !== 1'b0) begin n_fail++; $display("FAIL midrst_data: got data %h valid %b want 00 0", data_m, valid_m); end
        n_checks++; if (perr_m !== 1'b0 || ferr_m !== 1'b0 || ovf_m !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got %b%b%b want 000", perr_m, ferr_m, ovf_m); end
        reset = 1'b0;
        repeat (700) @(negedge clk);
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL midrst_abandon: got valid %b want 0", valid_m); end
        send_frame(0, 8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_m !== 8'h81) begin n_fail++; $display("FAIL post_rst_data: got %h want 81", data_m); end
        n_checks++; if (perr_m !== 1'b0 || ferr_m !== 1'b0 || ovf_m !== 1'b0 || valid_m !== 1'b1) begin n_fail++; $display("FAIL post_rst_flags: got p%b f%b o%b v%b want 0 0 0 1", perr_m, ferr_m, ovf_m, valid_m); end
    endtask

    task automatic test_seven_bit;
        send_frame(2, 8'h7F, 7, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_7 !== 8'h7F) begin n_fail++; $display("FAIL d7_7f_data: got %h want 7f", data_7); end
        n_checks++; if (valid_7 !== 1'b1 || ferr_7 !== 1'b0) begin n_fail++; $display("FAIL d7_7f_flags: got valid %b ferr %b want 1 0", valid_7, ferr_7); end
        pulse_read(2);
        send_frame(2, 8'h2A, 7, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_7 !== 8'h2A) begin n_fail++; $display("FAIL d7_2a_data: got %h want 2a", data_7); end
        n_checks++; if (ferr_7 !== 1'b0 || ovf_7 !== 1'b0) begin n_fail++; $display("FAIL d7_2a_flags: got ferr %b ovf %b want 0 0", ferr_7, ovf_7); end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_parity;
        test_framing;
        test_false_start;
        test_back_to_back;
        test_reset_mid_frame;
        test_seven_bit;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
